hazard_stall_ctrl: RTL and testbench

Pipeline hazard and stall sequencer for the 5-stage core, located in ID alongside the forwarding logic. It detects load-use hazards, flushes on taken branches, and runs a start/done handshake with the multi-cycle multiply/divide unit (MDU), with a timeout watchdog. From these it drives the PC write enable, the IF/ID write and flush, and the ID/EX bubble. It also keeps a saturating stall-cycle counter for performance reporting.

---
 rtl/hazard_stall_ctrl.sv | 155 +++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_stall_ctrl
//
// ID-stage hazard and stall sequencer for the 5-stage core. It detects load-use
// hazards, flushes IF/ID on taken branches and sequences the start/done
// handshake with the multi-cycle multiply/divide unit (MDU), guarded by a
// watchdog. A saturating counter records every cycle in which the PC is held.
//
// Parameters
//   MDU_MAX  max MDU_WAIT cycles before the watchdog aborts the wait (>= 2)
//   CNT_W    width of the stall-cycle counter
//
// Ports
//   clk_i            clock, rising edge
//   rst_i            asynchronous active-low reset
//   id_rs1/id_rs2    source registers of the instruction in ID
//   id_use_rs1/2     instruction in ID actually reads that source
//   id_mdu_op        instruction in ID is a multi-cycle MDU op
//   id_ex_rd         destination register of the instruction in EX
//   id_ex_mem_read   instruction in EX is a load
//   ex_branch_taken  EX resolved a taken branch/jump
//   mdu_done         MDU result valid (1-cycle pulse)
//   mdu_start        1-cycle pulse launching the MDU
//   pc_write         PC load enable
//   if_id_write      IF/ID load enable
//   if_id_flush      clear IF/ID contents
//   id_ex_bubble     load a NOP into ID/EX
//   mdu_err          sticky watchdog abort flag (cleared by reset only)
//   stall_cnt        saturating count of cycles with pc_write = 0
// -----------------------------------------------------------------------------
module hazard_stall_ctrl #(
  parameter int MDU_MAX = 32,
  parameter int CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             id_mdu_op,
  input  logic [4:0]       id_ex_rd,
  input  logic             id_ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             mdu_done,
  output logic             mdu_start,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             mdu_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int WAIT_W = $clog2(MDU_MAX + 1);

  typedef enum logic {
    RUN,
    MDU_WAIT
  } state_t;

  state_t              state_reg, state_next;
  logic [WAIT_W-1:0]   wait_cnt_reg, wait_cnt_next;
  logic [CNT_W-1:0]    stall_cnt_reg;
  logic                mdu_err_reg;
  logic                err_set;
  logic                load_use;

  // Register x0 is hard-wired to zero, so a load "to x0" never creates a hazard.
  assign load_use = id_ex_mem_read && (id_ex_rd != 5'd0) &&
                    ((id_use_rs1 && (id_rs1 == id_ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == id_ex_rd)));

  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    mdu_start     = 1'b0;
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    err_set       = 1'b0;

    case (state_reg)
      RUN: begin
        if (ex_branch_taken) begin
          // The wrong-path instruction in ID is squashed, so its hazards and
          // any MDU request it carries are irrelevant.
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
        end else if (load_use) begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
        end else if (id_mdu_op) begin
          mdu_start     = 1'b1;
          pc_write      = 1'b0;
          if_id_write   = 1'b0;
          id_ex_bubble  = 1'b1;
          wait_cnt_next = '0;
          state_next    = MDU_WAIT;
        end
      end

      MDU_WAIT: begin
        if (mdu_done) begin
          // Defaults let the MDU instruction advance into EX.
          state_next = RUN;
        end else if (wait_cnt_reg == WAIT_W'(MDU_MAX - 1)) begin
          // This is the MDU_MAX-th wait cycle: give up and release the pipe.
          err_set    = 1'b1;
          state_next = RUN;
        end else begin
          pc_write      = 1'b0;
          if_id_write   = 1'b0;
          id_ex_bubble  = 1'b1;
          wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
        end
      end

      default: state_next = RUN;
    endcase

    // While reset is held the pipeline must stay frozen with a NOP in ID/EX.
    if (!rst_i) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b1;
      mdu_start    = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg     <= RUN;
      wait_cnt_reg  <= '0;
      stall_cnt_reg <= '0;
      mdu_err_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      if (err_set) begin
        mdu_err_reg <= 1'b1;
      end
      if (!pc_write && (stall_cnt_reg != '1)) begin
        stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      end
    end
  end

  assign mdu_err   = mdu_err_reg;
  assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for hazard_stall_ctrl. Three instances share one stimulus stream:
//   a_*  default parameters (MDU_MAX=32, CNT_W=16)
//   w_*  MDU_MAX=4 for watchdog behaviour
//   s_*  CNT_W=3 for counter saturation
// Each task drives a table of rows; the expected control vector of a row is
// pushed to a queue when the row is driven and popped when outputs are sampled.
// Control vector order: {mdu_start, pc_write, if_id_write, if_id_flush, id_ex_bubble}
// -----------------------------------------------------------------------------
module tb_hazard_stall_ctrl;

  localparam logic [4:0] DEF   = 5'b01100;
  localparam logic [4:0] STALL = 5'b00001;
  localparam logic [4:0] START = 5'b10001;
  localparam logic [4:0] FLUSH = 5'b01111;
  localparam logic [4:0] RSTV  = 5'b00001;

  typedef struct packed {
    logic       br;
    logic       mr;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic       op;
    logic       done;
    logic [4:0] exp;
  } row_t;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_ex_rd = '0;
  logic       id_use_rs1 = 0, id_use_rs2 = 0, id_mdu_op = 0;
  logic       id_ex_mem_read = 0, ex_branch_taken = 0, mdu_done = 0;

  logic        a_start, a_pcw, a_ifw, a_flush, a_bub, a_err;
  logic [15:0] a_cnt;
  logic        w_start, w_pcw, w_ifw, w_flush, w_bub, w_err;
  logic [15:0] w_cnt;
  logic        s_start, s_pcw, s_ifw, s_flush, s_bub, s_err;
  logic [2:0]  s_cnt;

  int         checks = 0;
  int         errors = 0;
  int         exp_stall = 0;
  logic [4:0] exp_q[$];

  always #5 clk_i = ~clk_i;

  hazard_stall_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_mdu_op(id_mdu_op),
    .id_ex_rd(id_ex_rd), .id_ex_mem_read(id_ex_mem_read),
    .ex_branch_taken(ex_branch_taken), .mdu_done(mdu_done),
    .mdu_start(a_start), .pc_write(a_pcw), .if_id_write(a_ifw),
    .if_id_flush(a_flush), .id_ex_bubble(a_bub), .mdu_err(a_err), .stall_cnt(a_cnt)
  );

  hazard_stall_ctrl #(.MDU_MAX(4), .CNT_W(16)) dut_wd (
    .clk_i(clk_i), .rst_i(rst_i), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_mdu_op(id_mdu_op),
    .id_ex_rd(id_ex_rd), .id_ex_mem_read(id_ex_mem_read),
    .ex_branch_taken(ex_branch_taken), .mdu_done(mdu_done),
    .mdu_start(w_start), .pc_write(w_pcw), .if_id_write(w_ifw),
    .if_id_flush(w_flush), .id_ex_bubble(w_bub), .mdu_err(w_err), .stall_cnt(w_cnt)
  );

  hazard_stall_ctrl #(.MDU_MAX(32), .CNT_W(3)) dut_sat (
    .clk_i(clk_i), .rst_i(rst_i), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_mdu_op(id_mdu_op),
    .id_ex_rd(id_ex_rd), .id_ex_mem_read(id_ex_mem_read),
    .ex_branch_taken(ex_branch_taken), .mdu_done(mdu_done),
    .mdu_start(s_start), .pc_write(s_pcw), .if_id_write(s_ifw),
    .if_id_flush(s_flush), .id_ex_bubble(s_bub), .mdu_err(s_err), .stall_cnt(s_cnt)
  );

  function automatic row_t mk(input int br, input int mr, input int rd, input int rs1,
                              input int u1, input int rs2, input int u2, input int op,
                              input int dn, input logic [4:0] e);
    row_t r;
    r.br = (br != 0);  r.mr = (mr != 0);  r.rd = 5'(rd);  r.rs1 = 5'(rs1);
    r.u1 = (u1 != 0);  r.rs2 = 5'(rs2);   r.u2 = (u2 != 0);
    r.op = (op != 0);  r.done = (dn != 0); r.exp = e;
    return r;
  endfunction

  function automatic logic [4:0] ctrl_of(input int which);
    case (which)
      0:       return {a_start, a_pcw, a_ifw, a_flush, a_bub};
      1:       return {w_start, w_pcw, w_ifw, w_flush, w_bub};
      default: return {s_start, s_pcw, s_ifw, s_flush, s_bub};
    endcase
  endfunction

  function automatic logic [15:0] stall_of(input int which);
    case (which)
      0:       return a_cnt;
      1:       return w_cnt;
      default: return {13'd0, s_cnt};
    endcase
  endfunction

  task automatic drive(input row_t r);
    ex_branch_taken = r.br;  id_ex_mem_read = r.mr;  id_ex_rd = r.rd;
    id_rs1 = r.rs1;  id_use_rs1 = r.u1;  id_rs2 = r.rs2;  id_use_rs2 = r.u2;
    id_mdu_op = r.op;  mdu_done = r.done;
  endtask

  task automatic do_reset();
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF));
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    exp_stall = 0;
  endtask

  task automatic test_reset();
    logic [4:0] e;
    #2;
    exp_q.push_back(RSTV);
    e = exp_q.pop_front();
    checks++;
    if (ctrl_of(0) !== e) begin
      errors++; $display("FAIL reset_ctrl: got %b expected %b", ctrl_of(0), e);
    end
    checks++;
    if (a_cnt !== 16'd0 || a_err !== 1'b0) begin
      errors++; $display("FAIL reset_regs: cnt %0d err %b expected 0 0", a_cnt, a_err);
    end
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    exp_stall = 0;
    exp_q.push_back(DEF);
    #2;
    e = exp_q.pop_front();
    checks++;
    if (ctrl_of(0) !== e) begin
      errors++; $display("FAIL idle_ctrl: got %b expected %b", ctrl_of(0), e);
    end
    @(posedge clk_i); #1;
    checks++;
    if (a_cnt !== 16'd0) begin
      errors++; $display("FAIL idle_stall_cnt: got %0d expected 0", a_cnt);
    end
    $display("test_reset done");
  endtask

  task automatic test_load_use();
    row_t rows[$];
    logic [4:0] e, g;
    rows.push_back(mk(0, 1, 5, 0, 0, 5, 1, 0, 0, STALL));  // rs2 hazard
    rows.push_back(mk(0, 0, 5, 0, 0, 5, 1, 0, 0, DEF));    // bubble cleared it
    rows.push_back(mk(0, 1, 0, 0, 1, 0, 1, 0, 0, DEF));    // load to x0
    rows.push_back(mk(0, 1, 7, 7, 1, 3, 1, 0, 0, STALL));  // rs1 hazard
    rows.push_back(mk(0, 1, 7, 7, 0, 3, 1, 0, 0, DEF));    // rs1 not read
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF));
    for (int i = 0; i < rows.size(); i++) begin
      @(posedge clk_i); #1;
      checks++;
      if (stall_of(0) !== 16'(exp_stall)) begin
        errors++; $display("FAIL load_use_cnt row %0d: got %0d expected %0d", i, stall_of(0), exp_stall);
      end
      drive(rows[i]);
      exp_q.push_back(rows[i].exp);
      #2;
      g = ctrl_of(0);
      e = exp_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++; $display("FAIL load_use_ctrl row %0d: got %b expected %b", i, g, e);
      end
      if (!e[3]) exp_stall++;
      $display("load_use row %0d ctrl %b", i, g);
    end
  endtask

  task automatic test_branch();
    row_t rows[$];
    logic [4:0] e, g;
    rows.push_back(mk(1, 1, 5, 0, 0, 5, 1, 0, 0, FLUSH));  // branch beats load-use
    rows.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, FLUSH));  // branch beats mdu op
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF));
    for (int i = 0; i < rows.size(); i++) begin
      @(posedge clk_i); #1;
      checks++;
      if (stall_of(0) !== 16'(exp_stall)) begin
        errors++; $display("FAIL branch_cnt row %0d: got %0d expected %0d", i, stall_of(0), exp_stall);
      end
      drive(rows[i]);
      exp_q.push_back(rows[i].exp);
      #2;
      g = ctrl_of(0);
      e = exp_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++; $display("FAIL branch_ctrl row %0d: got %b expected %b", i, g, e);
      end
      if (!e[3]) exp_stall++;
      $display("branch row %0d ctrl %b", i, g);
    end
  endtask

  task automatic test_mdu();
    row_t rows[$];
    logic [4:0] e, g;
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, START));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, STALL));
    rows.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, STALL));  // branch ignored while waiting
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, STALL));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, DEF));    // done on 4th wait cycle
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, START));  // back-to-back MDU op
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, DEF));    // done on 1st wait cycle
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, DEF));    // stray done in RUN
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF));
    for (int i = 0; i < rows.size(); i++) begin
      @(posedge clk_i); #1;
      checks++;
      if (stall_of(0) !== 16'(exp_stall)) begin
        errors++; $display("FAIL mdu_cnt row %0d: got %0d expected %0d", i, stall_of(0), exp_stall);
      end
      drive(rows[i]);
      exp_q.push_back(rows[i].exp);
      #2;
      g = ctrl_of(0);
      e = exp_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++; $display("FAIL mdu_ctrl row %0d: got %b expected %b", i, g, e);
      end
      if (!e[3]) exp_stall++;
      $display("mdu row %0d ctrl %b", i, g);
    end
    // For MDU_MAX=4 the first done landed on the timeout cycle: not an error.
    checks++;
    if (a_err !== 1'b0 || w_err !== 1'b0) begin
      errors++; $display("FAIL mdu_err_clear: got a=%b w=%b expected 0 0", a_err, w_err);
    end
  endtask

  task automatic test_load_then_mdu();
    row_t rows[$];
    logic [4:0] e, g;
    rows.push_back(mk(0, 1, 5, 5, 1, 0, 0, 1, 0, STALL));  // load stall first
    rows.push_back(mk(0, 0, 5, 5, 1, 0, 0, 1, 0, START));  // then MDU launch
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, DEF));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF));
    for (int i = 0; i < rows.size(); i++) begin
      @(posedge clk_i); #1;
      checks++;
      if (stall_of(0) !== 16'(exp_stall)) begin
        errors++; $display("FAIL ld_mdu_cnt row %0d: got %0d expected %0d", i, stall_of(0), exp_stall);
      end
      drive(rows[i]);
      exp_q.push_back(rows[i].exp);
      #2;
      g = ctrl_of(0);
      e = exp_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++; $display("FAIL ld_mdu_ctrl row %0d: got %b expected %b", i, g, e);
      end
      if (!e[3]) exp_stall++;
      $display("load_then_mdu row %0d ctrl %b", i, g);
    end
  endtask

  task automatic test_watchdog();
    row_t rows[$];
    logic [4:0] e, g;
    do_reset();
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, START));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, STALL));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, STALL));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, STALL));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, DEF));    // 4th wait cycle: abort
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, DEF));    // late done in RUN
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF));
    for (int i = 0; i < rows.size(); i++) begin
      @(posedge clk_i); #1;
      checks++;
      if (stall_of(1) !== 16'(exp_stall) || w_err !== (i >= 5)) begin
        errors++; $display("FAIL wd_regs row %0d: cnt %0d err %b expected %0d %b", i, stall_of(1), w_err, exp_stall, (i >= 5));
      end
      drive(rows[i]);
      exp_q.push_back(rows[i].exp);
      #2;
      g = ctrl_of(1);
      e = exp_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++; $display("FAIL wd_ctrl row %0d: got %b expected %b", i, g, e);
      end
      if (!e[3]) exp_stall++;
      $display("watchdog row %0d ctrl %b", i, g);
    end
    @(posedge clk_i); #1;
    checks++;
    if (w_cnt !== 16'd4 || w_err !== 1'b1) begin
      errors++; $display("FAIL wd_final: cnt %0d err %b expected 4 1", w_cnt, w_err);
    end
  endtask

  task automatic test_saturate();
    row_t rows[$];
    logic [4:0] e, g;
    do_reset();
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, START));
    for (int k = 0; k < 10; k++) rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, STALL));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, DEF));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF));
    for (int i = 0; i < rows.size(); i++) begin
      @(posedge clk_i); #1;
      checks++;
      if (stall_of(2) !== 16'(exp_stall)) begin
        errors++; $display("FAIL sat_cnt row %0d: got %0d expected %0d", i, stall_of(2), exp_stall);
      end
      drive(rows[i]);
      exp_q.push_back(rows[i].exp);
      #2;
      g = ctrl_of(2);
      e = exp_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++; $display("FAIL sat_ctrl row %0d: got %b expected %b", i, g, e);
      end
      if (!e[3] && exp_stall < 7) exp_stall++;
      $display("saturate row %0d ctrl %b cnt %0d", i, g, s_cnt);
    end
    @(posedge clk_i); #1;
    checks++;
    if (s_cnt !== 3'd7 || s_err !== 1'b0) begin
      errors++; $display("FAIL sat_final: cnt %0d err %b expected 7 0", s_cnt, s_err);
    end
  endtask

  task automatic test_async_reset();
    logic [4:0] e, g;
    // Enter MDU_WAIT on the default instance, then pull reset mid-cycle.
    @(posedge clk_i); #1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, START));
    exp_q.push_back(START);
    #2;
    e = exp_q.pop_front();
    checks++;
    if (ctrl_of(0) !== e) begin
      errors++; $display("FAIL arst_start: got %b expected %b", ctrl_of(0), e);
    end
    @(posedge clk_i); #1;
    exp_q.push_back(STALL);
    #2;
    e = exp_q.pop_front();
    checks++;
    if (ctrl_of(0) !== e) begin
      errors++; $display("FAIL arst_wait: got %b expected %b", ctrl_of(0), e);
    end
    rst_i = 1'b0;
    exp_stall = 0;
    exp_q.push_back(RSTV);
    #1;
    e = exp_q.pop_front();
    g = ctrl_of(0);
    checks++;
    if (g !== e || a_cnt !== 16'd0) begin
      errors++; $display("FAIL arst_immediate: ctrl %b cnt %0d expected %b 0", g, a_cnt, e);
    end
    checks++;
    if (a_err !== 1'b0 || w_err !== 1'b0 || s_cnt !== 3'd0) begin
      errors++; $display("FAIL arst_regs: a_err %b w_err %b s_cnt %0d expected 0 0 0", a_err, w_err, s_cnt);
    end
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, DEF));  // stray done after abort
    exp_q.push_back(DEF);
    #2;
    e = exp_q.pop_front();
    checks++;
    if (ctrl_of(0) !== e) begin
      errors++; $display("FAIL arst_run: got %b expected %b", ctrl_of(0), e);
    end
    @(posedge clk_i); #1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF));
    checks++;
    if (a_cnt !== 16'(exp_stall) || a_err !== 1'b0) begin
      errors++; $display("FAIL arst_after: cnt %0d err %b expected %0d 0", a_cnt, a_err, exp_stall);
    end
    $display("test_async_reset done");
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_mdu();
    test_load_then_mdu();
    test_watchdog();
    test_saturate();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
